// File: rtl/dram_pkg.sv
// Shared dispatch-RAM definitions: word layout, sizes, diagnostic function codes
// and loader states. The IR board imports this package to unpack the same word.
package dram_pkg;

    localparam int unsigned DRAM_SIZE  = 512;
    localparam int unsigned DRAM_WIDTH = 15;
    localparam int unsigned DRAM_AW    = $clog2(DRAM_SIZE);
    localparam int unsigned DIAG_W     = 36;
    localparam int unsigned PAYLOAD_W  = DRAM_WIDTH - 1;

    // {A[0:2], B[0:2], P, J[1:4], J[7:10]}, MSB first
    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic       p;
        logic [3:0] j1_4;
        logic [3:0] j7_10;
    } tDRAMword;

    typedef enum logic [2:0] {
        F_LDAR   = 3'd0,
        F_AB     = 3'd1,
        F_P      = 3'd2,
        F_J1_4   = 3'd3,
        F_J7_10  = 3'd4,
        F_COMMIT = 3'd5,
        F_READ   = 3'd6,
        F_CLR    = 3'd7
    } tDRAMfunc;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_CHECK = 2'd3
    } tLoaderState;

    // The 14 bits that the parity bit covers
    function automatic logic [PAYLOAD_W-1:0] dram_payload(input tDRAMword w);
        return {w.a, w.b, w.j1_4, w.j7_10};
    endfunction

endpackage

// File: rtl/dram_parity.sv
// Odd-parity generator for the 14 payload bits of a DRAM word.
// Only instantiated when DRAM_PAR_GEN_EN is defined.
module dram_parity
    import dram_pkg::*;
(
    input  logic [PAYLOAD_W-1:0] data,
    output logic                 p_c
);

    // P makes the full 15-bit word carry an odd number of ones
    assign p_c = ~(^data);

endmodule

// File: rtl/dram_loader.sv
// Diagnostic write/verify engine for the 512x15 dispatch RAM (port b).
// Stages a word through diagnostic functions, writes it, reads it back,
// compares and auto-increments the address.
// Build option: DRAM_PAR_GEN_EN -- generate P as odd parity instead of staging it.
module dram_loader
    import dram_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  diagLoad,
    input  logic [2:0]            diagSel,
    input  logic [DIAG_W-1:0]     diagData,
    output logic                  busy,
    output logic                  done,
    output logic                  mismatch,
    output logic                  overrun,
    output logic [DRAM_AW-1:0]    addr,
    output logic [DRAM_WIDTH-1:0] rdData,
    output logic [DRAM_AW-1:0]    memAddr,
    output logic [DRAM_WIDTH-1:0] memDin,
    output logic                  memWe,
    output logic                  memEn,
    input  logic [DRAM_WIDTH-1:0] memDout
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_WRITE = ST_WRITE;
    localparam logic [1:0] S_READ  = ST_READ;
    localparam logic [1:0] S_CHECK = ST_CHECK;

    logic [1:0]            state_q,     state_d;
    logic                  is_commit_q, is_commit_d;
    tDRAMword              staged_q,    staged_d;
    logic [DRAM_AW-1:0]    addr_q,      addr_d;
    logic [DRAM_WIDTH-1:0] rd_data_q,   rd_data_d;
    logic                  mismatch_q,  mismatch_d;
    logic                  overrun_q,   overrun_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic [DRAM_AW-1:0]    mem_addr_q,  mem_addr_d;
    logic [DRAM_WIDTH-1:0] mem_din_q,   mem_din_d;
    logic                  mem_we_q,    mem_we_d;
    logic                  mem_en_q,    mem_en_d;

    tDRAMword word_c;
    tDRAMfunc func_c;
    logic     diag_unused_c;

    assign func_c = tDRAMfunc'(diagSel);

`ifdef DRAM_PAR_GEN_EN
    logic [PAYLOAD_W-1:0] payload_c;
    logic                 par_c;

    assign payload_c     = dram_payload(staged_q);
    assign diag_unused_c = ^{diagData[DIAG_W-1:9], staged_q.p};

    dram_parity u_parity (
        .data (payload_c),
        .p_c  (par_c)
    );

    // Word actually written: staged fields with generated parity
    always_comb begin
        word_c   = staged_q;
        word_c.p = par_c;
    end
`else
    assign diag_unused_c = ^diagData[DIAG_W-1:9];

    // Word actually written: staged fields verbatim, P included
    always_comb begin
        word_c = staged_q;
    end
`endif

    // Next-state, staging, sticky flags and port-b drive
    always_comb begin
        state_d     = state_q;
        is_commit_d = is_commit_q;
        staged_d    = staged_q;
        addr_d      = addr_q;
        rd_data_d   = rd_data_q;
        mismatch_d  = mismatch_q;
        overrun_d   = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (diagLoad) begin
                    case (func_c)
                        F_LDAR: begin
                            addr_d   = diagData[DRAM_AW-1:0];
                            staged_d = '0;
                        end
                        F_AB: begin
                            staged_d.a = diagData[5:3];
                            staged_d.b = diagData[2:0];
                        end
                        F_P: begin
`ifndef DRAM_PAR_GEN_EN
                            staged_d.p = diagData[0];
`endif
                        end
                        F_J1_4:  staged_d.j1_4  = diagData[3:0];
                        F_J7_10: staged_d.j7_10 = diagData[3:0];
                        F_COMMIT: begin
                            state_d     = S_WRITE;
                            is_commit_d = 1'b1;
                        end
                        F_READ: begin
                            state_d     = S_READ;
                            is_commit_d = 1'b0;
                        end
                        F_CLR: begin
                            mismatch_d = 1'b0;
                            overrun_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_WRITE: state_d = S_READ;
            S_READ:  state_d = S_CHECK;
            S_CHECK: begin
                state_d   = S_IDLE;
                rd_data_d = memDout;
                if (is_commit_q) begin
                    if (tDRAMword'(memDout) != word_c) begin
                        mismatch_d = 1'b1;
                    end
                    addr_d = addr_q + DRAM_AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Any strobe during a sequence is dropped and flagged
        if (diagLoad && busy_q) begin
            overrun_d = 1'b1;
        end

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_CHECK);
        mem_en_d   = (state_d == S_WRITE) || (state_d == S_READ);
        mem_we_d   = (state_d == S_WRITE);
        mem_addr_d = addr_q;
        mem_din_d  = word_c;
    end

    // Registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            is_commit_q <= 1'b0;
            staged_q    <= '0;
            addr_q      <= '0;
            rd_data_q   <= '0;
            mismatch_q  <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_commit_q <= is_commit_d;
            staged_q    <= staged_d;
            addr_q      <= addr_d;
            rd_data_q   <= rd_data_d;
            mismatch_q  <= mismatch_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            mem_en_q    <= mem_en_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mismatch = mismatch_q;
    assign overrun  = overrun_q;
    assign addr     = addr_q;
    assign rdData   = rd_data_q;
    assign memAddr  = mem_addr_q;
    assign memDin   = mem_din_q;
    assign memWe    = mem_we_q;
    assign memEn    = mem_en_q;

endmodule

// File: tb/tb_dram_loader.sv
// Bench for dram_loader: random staging/commit/read traffic against a word-level
// model of the loader and of the DRAM contents. Honors DRAM_PAR_GEN_EN.
module tb_dram_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        diagLoad = 1'b0;
    logic [2:0]  diagSel = 3'd0;
    logic [35:0] diagData = 36'd0;
    logic        busy, done, mismatch, overrun, memWe, memEn;
    logic [8:0]  addr, memAddr;
    logic [14:0] rdData, memDin, memDout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dram_loader dut (
        .clk      (clk),
        .reset    (reset),
        .diagLoad (diagLoad),
        .diagSel  (diagSel),
        .diagData (diagData),
        .busy     (busy),
        .done     (done),
        .mismatch (mismatch),
        .overrun  (overrun),
        .addr     (addr),
        .rdData   (rdData),
        .memAddr  (memAddr),
        .memDin   (memDin),
        .memWe    (memWe),
        .memEn    (memEn),
        .memDout  (memDout)
    );

    // sim_mem: port-b DRAM model with one-cycle registered read
    logic [14:0] sim_mem [0:511];
    logic [14:0] mem_q = 15'd0;
    logic        corrupt = 1'b0;

    always @(posedge clk) begin
        if (memEn) begin
            if (memWe) sim_mem[memAddr] <= memDin;
            mem_q <= sim_mem[memAddr];
        end
    end

    assign memDout = mem_q ^ (corrupt ? 15'h0010 : 15'h0000);

    // Reference model state
    int m_addr = 0;
    int m_a = 0, m_b = 0, m_p = 0, m_j1 = 0, m_j7 = 0;
    bit m_mismatch = 0, m_overrun = 0;
    int model_mem [512];
    logic [14:0] last_din;

    function automatic int exp_word();
        int other, ones, p;
        other = m_a * 4096 + m_b * 512 + m_j1 * 16 + m_j7;
        ones = 0;
        for (int i = 0; i < 15; i++) ones += (other >> i) & 1;
`ifdef DRAM_PAR_GEN_EN
        p = (ones % 2 == 0) ? 1 : 0;
`else
        p = m_p;
`endif
        return other + p * 256;
    endfunction

    task automatic strobe(input int sel, input int field);
        @(negedge clk);
        diagLoad = 1'b1;
        diagSel  = 3'(sel);
        diagData = {27'($urandom), 9'(field)};
        @(negedge clk);
        diagLoad = 1'b0;
    endtask

    task automatic ldar(input int a);
        strobe(0, a);
        m_addr = a; m_a = 0; m_b = 0; m_p = 0; m_j1 = 0; m_j7 = 0;
    endtask

    task automatic stage(input int a, input int b, input int p, input int j1, input int j7);
        strobe(1, a * 8 + b);  m_a = a; m_b = b;
        strobe(2, p);          m_p = p;
        strobe(3, j1);         m_j1 = j1;
        strobe(4, j7);         m_j7 = j7;
    endtask

    task automatic clr();
        strobe(7, 0);
        m_mismatch = 0; m_overrun = 0;
    endtask

    // Drives one COMMIT and checks every cycle of the sequence
    task automatic commit_check(input string nm, input bit corrupt_it);
        int a0, w, rd;
        a0 = m_addr;
        w  = exp_word();
        strobe(5, 0);
        last_din = memDin;
        total++;
        if ({busy, memWe, memEn} !== 3'b111 || memAddr !== 9'(a0) || memDin !== 15'(w)) begin
            bad++;
            $display("FAIL %s write cycle: busy/we/en=%b addr=%0d din=%h, want 111 addr=%0d din=%h",
                     nm, {busy, memWe, memEn}, memAddr, memDin, a0, 15'(w));
        end
        model_mem[a0] = w;
        @(negedge clk);
        total++;
        if ({busy, memWe, memEn, done} !== 4'b1010 || memAddr !== 9'(a0)) begin
            bad++;
            $display("FAIL %s read cycle: busy/we/en/done=%b addr=%0d, want 1010 addr=%0d",
                     nm, {busy, memWe, memEn, done}, memAddr, a0);
        end
        if (corrupt_it) corrupt = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, memEn, memWe} !== 4'b1100) begin
            bad++;
            $display("FAIL %s check cycle: busy/done/en/we=%b want 1100", nm, {busy, done, memEn, memWe});
        end
        @(negedge clk);
        corrupt = 1'b0;
        rd = corrupt_it ? (w ^ 16) : w;
        if (corrupt_it) m_mismatch = 1;
        m_addr = (a0 + 1) % 512;
        total++;
        if ({busy, done} !== 2'b00 || addr !== 9'(m_addr) || rdData !== 15'(rd) ||
            mismatch !== m_mismatch || overrun !== m_overrun) begin
            bad++;
            $display("FAIL %s after: busy/done=%b addr=%0d rd=%h mis=%b ovr=%b, want 00 addr=%0d rd=%h mis=%b ovr=%b",
                     nm, {busy, done}, addr, rdData, mismatch, overrun, m_addr, 15'(rd), m_mismatch, m_overrun);
        end
    endtask

    // Drives one READ and checks the sequence and readback
    task automatic read_check(input string nm);
        int a0;
        a0 = m_addr;
        strobe(6, 0);
        total++;
        if ({busy, memWe, memEn} !== 3'b101 || memAddr !== 9'(a0)) begin
            bad++;
            $display("FAIL %s read cycle: busy/we/en=%b addr=%0d, want 101 addr=%0d",
                     nm, {busy, memWe, memEn}, memAddr, a0);
        end
        @(negedge clk);
        total++;
        if ({busy, done, memEn} !== 3'b110) begin
            bad++;
            $display("FAIL %s check cycle: busy/done/en=%b want 110", nm, {busy, done, memEn});
        end
        @(negedge clk);
        total++;
        if ({busy, done} !== 2'b00 || addr !== 9'(a0) || rdData !== 15'(model_mem[a0])) begin
            bad++;
            $display("FAIL %s after: busy/done=%b addr=%0d rd=%h, want 00 addr=%0d rd=%h",
                     nm, {busy, done}, addr, rdData, a0, 15'(model_mem[a0]));
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        diagLoad = 1'b1; diagSel = 3'd0; diagData = 36'h0_0000_0055;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, mismatch, overrun, memWe, memEn} !== 6'b0 || addr !== 9'd0 ||
            rdData !== 15'd0 || memAddr !== 9'd0 || memDin !== 15'd0) begin
            bad++;
            $display("FAIL reset: flags=%b addr=%0d rd=%h maddr=%0d din=%h, want all zero",
                     {busy, done, mismatch, overrun, memWe, memEn}, addr, rdData, memAddr, memDin);
        end
        diagLoad = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_basic_commit();
        ldar(0);
        stage(3, 5, 0, 10, 7);
        commit_check("basic", 1'b0);
    endtask

    task automatic test_wrap();
        ldar(511);
        stage(6, 1, 1, 4, 9);
        commit_check("wrap", 1'b0);
        ldar(511);
        read_check("wrap_read");
    endtask

    task automatic test_overrun();
        int n;
        ldar(40);
        stage(2, 2, 1, 5, 3);
        strobe(5, 0);
        @(negedge clk);
        diagLoad = 1'b1; diagSel = 3'd3; diagData = 36'h0_0000_000F;
        @(negedge clk);
        diagLoad = 1'b0;
        model_mem[40] = exp_word();
        m_addr = 41; m_overrun = 1;
        n = 0;
        while (busy === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0 || overrun !== 1'b1 || addr !== 9'd41) begin
            bad++;
            $display("FAIL overrun_set: busy=%b ovr=%b addr=%0d, want 0 1 41", busy, overrun, addr);
        end
        commit_check("ovr_keep_j", 1'b0);
        clr();
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clr: ovr=%b want 0", overrun);
        end
    endtask

    task automatic test_mismatch();
        ldar(200);
        stage(1, 7, 0, 12, 2);
        commit_check("mis_bad", 1'b1);
        commit_check("mis_sticky1", 1'b0);
        stage(4, 0, 1, 1, 15);
        commit_check("mis_sticky2", 1'b0);
        clr();
        total++;
        if (mismatch !== 1'b0) begin
            bad++;
            $display("FAIL mismatch_clr: mis=%b want 0", mismatch);
        end
        ldar(200);
        read_check("mis_readback");
    endtask

    task automatic test_parity();
        ldar(20);
        stage(0, 0, 0, 0, 0);
        commit_check("par_zero", 1'b0);
        total++;
`ifdef DRAM_PAR_GEN_EN
        if (last_din[8] !== 1'b1) begin
            bad++;
            $display("FAIL par_gen: P=%b want 1", last_din[8]);
        end
`else
        if (last_din[8] !== 1'b0 || (^last_din) !== 1'b0) begin
            bad++;
            $display("FAIL par_verbatim: P=%b xor=%b want 0 0", last_din[8], ^last_din);
        end
`endif
    endtask

    task automatic test_random();
        int addrs[$];
        for (int i = 0; i < 16; i++) begin
            ldar($urandom_range(511, 0));
            stage($urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(1, 0),
                  $urandom_range(15, 0), $urandom_range(15, 0));
            addrs.push_back(m_addr);
            commit_check("rand_commit", 1'b0);
            if ($urandom_range(1, 0) == 1) commit_check("rand_repeat", 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            ldar(addrs[$urandom_range(15, 0)]);
            read_check("rand_read");
        end
    endtask

    task automatic test_reset_in_write();
        ldar(100);
        stage(5, 3, 1, 9, 6);
        strobe(5, 0);
        total++;
        if (memWe !== 1'b1) begin
            bad++;
            $display("FAIL rst_write_pre: we=%b want 1", memWe);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({memWe, memEn, busy, done} !== 4'b0000 || addr !== 9'd0) begin
            bad++;
            $display("FAIL rst_write: we/en/busy/done=%b addr=%0d want 0000 0", {memWe, memEn, busy, done}, addr);
        end
        m_addr = 0; m_a = 0; m_b = 0; m_p = 0; m_j1 = 0; m_j7 = 0;
        m_mismatch = 0; m_overrun = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_no_done: done=%b busy=%b want 0 0", done, busy);
            end
        end
        commit_check("rst_staged_clear", 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) model_mem[i] = 0;
        test_reset();
        test_basic_commit();
        test_wrap();
        test_overrun();
        test_mismatch();
        test_parity();
        test_random();
        test_reset_in_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
